// File: rtl/expr_pipe.sv
// expr_pipe: q = ((a - b)*(3c + 1) - 4d) >>> 1 with per-operand valid/ready join,
// three stall-able arithmetic stages and saturate-or-wrap result with overflow flag.
module expr_pipe #(
   parameter int DATA_WIDTH = 16,
   parameter bit SATURATE   = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  arst_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   input  logic [DATA_WIDTH-1:0] c_i,
   input  logic [DATA_WIDTH-1:0] d_i,
   input  logic                  a_valid_i,
   input  logic                  b_valid_i,
   input  logic                  c_valid_i,
   input  logic                  d_valid_i,
   output logic                  a_ready_o,
   output logic                  b_ready_o,
   output logic                  c_ready_o,
   output logic                  d_ready_o,
   output logic [DATA_WIDTH-1:0] q_o,
   output logic                  ovf_o,
   output logic                  q_valid_o,
   input  logic                  q_ready_i
);
   localparam int W  = DATA_WIDTH;
   localparam int PW = 2*W + 4;

   logic [3:0][W-1:0] w_op_dat;
   logic [3:0]        w_op_vld;
   logic [3:0]        w_rdy;
   logic [3:0]        w_cap;
   logic              w_fire;
   logic              w_s1_adv;
   logic              w_s2_adv;
   logic              w_s3_adv;

   logic [3:0][W-1:0] r_hold;
   logic [3:0]        r_held;

   logic              r_v1;
   logic [W:0]        r_s1_ab;
   logic [W+2:0]      r_s1_c3;
   logic [W+1:0]      r_s1_d4;

   logic              r_v2;
   logic [PW-1:0]     r_s2_p;
   logic [W+1:0]      r_s2_d4;

   logic              r_v3;
   logic [W-1:0]      r_q;
   logic              r_ovf;

   assign w_op_dat = {d_i, c_i, b_i, a_i};
   assign w_op_vld = {d_valid_i, c_valid_i, b_valid_i, a_valid_i};

   // Stall chain: each stage may move if it is empty or the one after it moves.
   assign w_s3_adv = !r_v3 || q_ready_i;
   assign w_s2_adv = !r_v2 || w_s3_adv;
   assign w_s1_adv = !r_v1 || w_s2_adv;
   assign w_fire   = (&r_held) && w_s1_adv;
   assign w_rdy    = ~r_held | {4{w_fire}};
   assign w_cap    = w_op_vld & w_rdy;

   assign a_ready_o = w_rdy[0];
   assign b_ready_o = w_rdy[1];
   assign c_ready_o = w_rdy[2];
   assign d_ready_o = w_rdy[3];

   // A capture in the fire cycle refills the slot, so capture wins over clear.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_hold <= '0;
         r_held <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (w_cap[i]) begin
               r_hold[i] <= w_op_dat[i];
               r_held[i] <= 1'b1;
            end else if (w_fire) begin
               r_held[i] <= 1'b0;
            end
         end
      end
   end

   logic [W-1:0]   w_a;
   logic [W-1:0]   w_b;
   logic [W-1:0]   w_c;
   logic [W-1:0]   w_d;
   logic [W:0]     w_ab;
   logic [W+2:0]   w_c_x;
   logic [W+2:0]   w_c3;
   logic [W+1:0]   w_d4;

   assign w_a   = r_hold[0];
   assign w_b   = r_hold[1];
   assign w_c   = r_hold[2];
   assign w_d   = r_hold[3];
   assign w_ab  = {w_a[W-1], w_a} - {w_b[W-1], w_b};
   assign w_c_x = {{3{w_c[W-1]}}, w_c};
   assign w_c3  = w_c_x + {w_c_x[W+1:0], 1'b0} + {{(W+2){1'b0}}, 1'b1};
   assign w_d4  = {w_d, 2'b00};

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_v1    <= 1'b0;
         r_s1_ab <= '0;
         r_s1_c3 <= '0;
         r_s1_d4 <= '0;
      end else if (w_s1_adv) begin
         r_v1 <= w_fire;
         if (w_fire) begin
            r_s1_ab <= w_ab;
            r_s1_c3 <= w_c3;
            r_s1_d4 <= w_d4;
         end
      end
   end

   // Both factors sign-extended to the product width, so the low bits are the signed product.
   logic [PW-1:0] w_p;
   assign w_p = {{(W+3){r_s1_ab[W]}}, r_s1_ab} * {{(W+1){r_s1_c3[W+2]}}, r_s1_c3};

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_v2    <= 1'b0;
         r_s2_p  <= '0;
         r_s2_d4 <= '0;
      end else if (w_s2_adv) begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_s2_p  <= w_p;
            r_s2_d4 <= r_s1_d4;
         end
      end
   end

   logic signed [PW:0] w_diff;
   logic signed [PW:0] w_r;
   logic [PW-W+1:0]    w_top;
   logic               w_ovf;
   logic [W-1:0]       w_sat;
   logic [W-1:0]       w_q;

   assign w_diff = $signed({r_s2_p[PW-1], r_s2_p}) - $signed({{(W+3){r_s2_d4[W+1]}}, r_s2_d4});
   assign w_r    = w_diff >>> 1;
   // Result fits in W bits only when everything from the W-bit sign position up is uniform.
   assign w_top  = w_r[PW:W-1];
   assign w_ovf  = !((&w_top) || !(|w_top));
   assign w_sat  = w_r[PW] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
   assign w_q    = (SATURATE && w_ovf) ? w_sat : w_r[W-1:0];

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_v3  <= 1'b0;
         r_q   <= '0;
         r_ovf <= 1'b0;
      end else if (w_s3_adv) begin
         r_v3 <= r_v2;
         if (r_v2) begin
            r_q   <= w_q;
            r_ovf <= w_ovf;
         end
      end
   end

   assign q_o       = r_q;
   assign ovf_o     = r_ovf;
   assign q_valid_o = r_v3;

endmodule

// File: tb/tb_expr_pipe.sv
// Bench for expr_pipe: saturating and wrapping instances share stimulus; a scoreboard
// queue fed at issue time is drained by an independent output monitor.
module tb_expr_pipe;
   localparam int W = 16;

   typedef struct packed {
      logic [W-1:0] qs;
      logic [W-1:0] qw;
      logic         ovf;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         arst;
   logic [W-1:0] op [4];
   logic         vld [4];
   logic         q_ready = 1'b1;
   wire  [3:0]   rdy;
   wire  [3:0]   rdy1;
   wire  [W-1:0] q0;
   wire  [W-1:0] q1;
   wire          ov0;
   wire          ov1;
   wire          qv0;
   wire          qv1;

   int           total = 0;
   int           bad = 0;
   exp_t         expq[$];
   logic [W-1:0] sets [256][4];
   int           nset = 0;
   bit           abort = 1'b0;
   int           qr_mode = 0;

   expr_pipe #(.DATA_WIDTH(W), .SATURATE(1'b1)) dut_sat (
      .clk_i(clk), .arst_i(arst),
      .a_i(op[0]), .b_i(op[1]), .c_i(op[2]), .d_i(op[3]),
      .a_valid_i(vld[0]), .b_valid_i(vld[1]), .c_valid_i(vld[2]), .d_valid_i(vld[3]),
      .a_ready_o(rdy[0]), .b_ready_o(rdy[1]), .c_ready_o(rdy[2]), .d_ready_o(rdy[3]),
      .q_o(q0), .ovf_o(ov0), .q_valid_o(qv0), .q_ready_i(q_ready)
   );

   expr_pipe #(.DATA_WIDTH(W), .SATURATE(1'b0)) dut_wrap (
      .clk_i(clk), .arst_i(arst),
      .a_i(op[0]), .b_i(op[1]), .c_i(op[2]), .d_i(op[3]),
      .a_valid_i(vld[0]), .b_valid_i(vld[1]), .c_valid_i(vld[2]), .d_valid_i(vld[3]),
      .a_ready_o(rdy1[0]), .b_ready_o(rdy1[1]), .c_ready_o(rdy1[2]), .d_ready_o(rdy1[3]),
      .q_o(q1), .ovf_o(ov1), .q_valid_o(qv1), .q_ready_i(q_ready)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic note_fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: bound expired or unexpected event at %0t", name, $time);
   endtask

   function automatic exp_t model(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                                  input logic signed [W-1:0] c, input logic signed [W-1:0] d);
      exp_t   e;
      longint r;
      longint maxv;
      longint minv;
      maxv  = (longint'(1) <<< (W-1)) - 1;
      minv  = -(longint'(1) <<< (W-1));
      r     = ((longint'(a) - longint'(b)) * (3 * longint'(c) + 1) - 4 * longint'(d)) >>> 1;
      e.ovf = (r > maxv) || (r < minv);
      e.qw  = r[W-1:0];
      if (r > maxv)      e.qs = {1'b0, {(W-1){1'b1}}};
      else if (r < minv) e.qs = {1'b1, {(W-1){1'b0}}};
      else               e.qs = r[W-1:0];
      return e;
   endfunction

   function automatic logic [W-1:0] rnd_val();
      logic [W-1:0] v;
      case ($urandom_range(7, 0))
         0:       v = 16'h7fff;
         1:       v = 16'h8000;
         2:       v = W'($urandom_range(16, 0)) - W'(8);
         default: v = W'($urandom);
      endcase
      return v;
   endfunction

   task automatic put_set(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] c, input logic [W-1:0] d);
      sets[nset][0] = a;
      sets[nset][1] = b;
      sets[nset][2] = c;
      sets[nset][3] = d;
      nset++;
   endtask

   task automatic add_lit(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                          input logic [W-1:0] d, input logic [W-1:0] qs, input logic [W-1:0] qw,
                          input logic ovf);
      exp_t e;
      put_set(a, b, c, d);
      e.qs = qs;
      e.qw = qw;
      e.ovf = ovf;
      expq.push_back(e);
   endtask

   task automatic add_rand();
      logic [W-1:0] a, b, c, d;
      a = rnd_val();
      b = rnd_val();
      c = rnd_val();
      d = rnd_val();
      put_set(a, b, c, d);
      expq.push_back(model(a, b, c, d));
   endtask

   // Must be entered at a falling edge; each operand is offered until its handshake is seen.
   task automatic stream_op(input int k, input int first, input int n, input int maxgap);
      int g;
      int guard;
      for (int i = first; i < first + n; i++) begin
         g = $urandom_range(maxgap, 0);
         repeat (g) begin
            vld[k] = 1'b0;
            @(negedge clk);
         end
         if (abort) begin
            vld[k] = 1'b0;
            return;
         end
         op[k]  = sets[i][k];
         vld[k] = 1'b1;
         guard  = 0;
         #1;
         while (!rdy[k] && !abort && guard < 500) begin
            @(negedge clk);
            #1;
            guard++;
         end
         if (guard >= 500) note_fail("operand_handshake_timeout");
         @(negedge clk);
      end
      vld[k] = 1'b0;
   endtask

   task automatic wait_drain();
      int guard = 0;
      while (expq.size() != 0 && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 400) note_fail("drain_timeout");
      repeat (3) @(negedge clk);
   endtask

   always @(negedge clk) begin
      case (qr_mode)
         0:       q_ready = 1'b1;
         1:       q_ready = ($urandom_range(3, 0) != 0);
         default: q_ready = 1'b0;
      endcase
   end

   logic         stall_seen = 1'b0;
   logic [W-1:0] held_q0;
   logic [W-1:0] held_q1;
   logic         held_ovf;

   always @(negedge clk) begin
      exp_t e;
      #2;
      chk("ready_match", rdy1, rdy);
      chk("valid_match", qv1, qv0);
      if (arst) begin
         stall_seen = 1'b0;
      end else if (qv0) begin
         if (stall_seen) begin
            chk("stall_q_stable", q0, held_q0);
            chk("stall_qwrap_stable", q1, held_q1);
            chk("stall_ovf_stable", ov0, held_ovf);
         end
         if (q_ready) begin
            stall_seen = 1'b0;
            if (expq.size() == 0) begin
               note_fail("unexpected_result");
            end else begin
               e = expq.pop_front();
               chk("q_sat", q0, e.qs);
               chk("q_wrap", q1, e.qw);
               chk("ovf_sat", ov0, e.ovf);
               chk("ovf_wrap", ov1, e.ovf);
            end
         end else begin
            stall_seen = 1'b1;
            held_q0    = q0;
            held_q1    = q1;
            held_ovf   = ov0;
         end
      end else begin
         if (stall_seen) chk("valid_dropped_in_stall", qv0, 1);
         stall_seen = 1'b0;
      end
   end

   initial begin
      int first;
      arst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         vld[k] = 1'b0;
         op[k]  = '0;
      end
      repeat (2) @(negedge clk);
      #2;
      chk("reset_q_valid", qv0, 0);
      chk("reset_q", q0, 0);
      chk("reset_ovf", ov0, 0);
      chk("reset_ready", rdy, 4'hf);
      for (int k = 0; k < 4; k++) vld[k] = 1'b1;
      #1;
      chk("reset_ready_with_valid", rdy, 4'hf);
      for (int k = 0; k < 4; k++) vld[k] = 1'b0;
      @(negedge clk);
      arst = 1'b0;

      // Basic: all operands together, exact latency and a single-cycle result.
      add_lit(16'd10, 16'd3, 16'd2, 16'd1, 16'd22, 16'd22, 1'b0);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         op[k]  = sets[nset-1][k];
         vld[k] = 1'b1;
      end
      for (int i = 0; i < 6; i++) begin
         if (i > 0) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) vld[k] = 1'b0;
         end
         #2;
         if (i == 0) chk("basic_ready", rdy, 4'hf);
         if (i >= 1 && i <= 3) chk("basic_latency", qv0, 0);
         if (i == 4) chk("basic_valid", qv0, 1);
         if (i == 5) chk("basic_one_cycle", qv0, 0);
      end

      // Negative floor, both overflow modes, and a negative extreme.
      first = nset;
      add_lit(16'd0, 16'd1, 16'd0, 16'd0, 16'hffff, 16'hffff, 1'b0);
      add_lit(16'h7fff, 16'h8000, 16'h7fff, 16'h0000, 16'd32767, 16'd16385, 1'b1);
      put_set(16'h8000, 16'h7fff, 16'h7fff, 16'h8000);
      expq.push_back(model(16'h8000, 16'h7fff, 16'h7fff, 16'h8000));
      @(negedge clk);
      fork
         stream_op(0, first, 3, 2);
         stream_op(1, first, 3, 2);
         stream_op(2, first, 3, 2);
         stream_op(3, first, 3, 2);
      join
      wait_drain();

      // Out-of-order join: d at edge 0, a at edge 2, b and c at edge 5.
      add_lit(16'd10, 16'd3, 16'd2, 16'd1, 16'd22, 16'd22, 1'b0);
      for (int k = 0; k < 4; k++) op[k] = sets[nset-1][k];
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         vld[3] = (i == 0);
         vld[0] = (i == 2);
         vld[1] = (i == 5);
         vld[2] = (i == 5);
         #2;
         if (i >= 1 && i <= 5) chk("ooo_d_ready_low", rdy[3], 0);
         if (i >= 3 && i <= 5) chk("ooo_a_ready_low", rdy[0], 0);
         if (i == 6) chk("ooo_fire_ready", rdy, 4'hf);
         if (i == 8) chk("ooo_not_yet_valid", qv0, 0);
         if (i == 9) chk("ooo_valid", qv0, 1);
      end
      wait_drain();

      // Backpressure: 8 back-to-back sets, downstream stalled for falling edges 3..9.
      first = nset;
      for (int i = 0; i < 8; i++) add_rand();
      @(negedge clk);
      fork
         stream_op(0, first, 8, 0);
         stream_op(1, first, 8, 0);
         stream_op(2, first, 8, 0);
         stream_op(3, first, 8, 0);
         begin
            for (int i = 0; i < 12; i++) begin
               if (i > 0) @(negedge clk);
               #2;
               if (i == 8 || i == 9) begin
                  chk("bp_ready_low", rdy, 0);
                  chk("bp_valid_held", qv0, 1);
               end
               #1;
               if (i == 2) qr_mode = 2;
               if (i == 9) qr_mode = 0;
            end
         end
      join
      wait_drain();

      // Random operands, random gaps, random downstream readiness.
      first = nset;
      for (int i = 0; i < 40; i++) add_rand();
      qr_mode = 1;
      @(negedge clk);
      fork
         stream_op(0, first, 40, 3);
         stream_op(1, first, 40, 3);
         stream_op(2, first, 40, 3);
         stream_op(3, first, 40, 3);
      join
      qr_mode = 0;
      wait_drain();

      // Reset with two results in flight and a set held: everything is discarded.
      first = nset;
      for (int i = 0; i < 6; i++) add_rand();
      @(negedge clk);
      fork
         stream_op(0, first, 6, 0);
         stream_op(1, first, 6, 0);
         stream_op(2, first, 6, 0);
         stream_op(3, first, 6, 0);
         begin
            for (int i = 0; i < 5; i++) begin
               if (i > 0) @(negedge clk);
               if (i == 2) begin
                  #3;
                  abort = 1'b1;
               end
               if (i == 3) begin
                  arst = 1'b1;
                  for (int k = 0; k < 4; k++) vld[k] = 1'b0;
                  expq.delete();
                  #1;
                  chk("midrst_q_valid", qv0, 0);
                  chk("midrst_ready", rdy, 4'hf);
               end
               if (i == 4) arst = 1'b0;
            end
         end
      join
      abort = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         #2;
         chk("no_stale_result", qv0, 0);
      end

      // Pipeline still works after the mid-stream reset.
      first = nset;
      add_lit(16'd10, 16'd3, 16'd2, 16'd1, 16'd22, 16'd22, 1'b0);
      @(negedge clk);
      fork
         stream_op(0, first, 1, 1);
         stream_op(1, first, 1, 1);
         stream_op(2, first, 1, 1);
         stream_op(3, first, 1, 1);
      join
      wait_drain();

      chk("scoreboard_empty", expq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
